telemetre_us_multi: RTL and testbench
=====================================

# telemetre_us_multi

Multi-channel ultrasonic rangefinder controller for the 2D radar: the parametrised successor of the single-channel telemetre. It drives N_CH HC-SR04-class sensors in round-robin order, so only one sensor fires at a time and there is no acoustic crosstalk. For each channel it measures the echo pulse directly in centimetres and publishes a per-channel distance, a valid strobe and a timeout flag. It sits between the sensor GPIO conduit and the Avalon register wrapper / servo sweep logic.

## Interface
Parameters:
- CLK_FREQ_HZ, 50_000_000: clock frequency; sets all time bases.
- N_CH, 4: number of sensor channels, 1..8.
- DIST_W, 10: width of each distance field in bits.
- MAX_CM, 400: saturation distance; reaching it counts as an out-of-range timeout. Must be < 2^DIST_W.
- TRIG_US, 10: trigger pulse width in µs.
- RISE_TO_US, 30000: maximum wait from the end of trig to the echo rising edge.
- GAP_US, 60000: quiet time after each channel, before the next channel fires.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run the scan while high
- echo  in  N_CH  raw echo inputs, asynchronous
- trig  out  N_CH  trigger outputs, one-hot or zero
- dist_cm  out  N_CH*DIST_W  channel c occupies bits [c*DIST_W +: DIST_W]
- valid  out  N_CH  one-cycle strobe on each channel update
- timeout  out  N_CH  sticky per channel: last measurement of that channel timed out
- busy  out  1  high when the FSM is not in IDLE
- ch_idx  out  $clog2(N_CH) (min 1)  channel currently addressed

## Operation
- Each echo bit passes through a 2-FF synchroniser. All edge detection uses the synchronised value.
- Derived constants:
  - TRIG_CYC = TRIG_US*CLK_FREQ_HZ/1e6
  - CM_CYC = 58*CLK_FREQ_HZ/1e6
  - RISE_CYC and GAP_CYC are derived from their µs parameters the same way.
  - All are integer-truncated at elaboration.
- FSM states:
  - IDLE: if enable, go to TRIG with ch_idx unchanged.
  - TRIG: trig[ch_idx]=1 for TRIG_CYC cycles, then go to WAIT_RISE.
  - WAIT_RISE: on a synchronised echo rising edge, go to MEASURE. After RISE_CYC cycles without one, record a timeout and go to GAP.
  - MEASURE: a prescaler counts 0..CM_CYC-1; on wrap, cm_cnt increments. On the echo falling edge, record cm_cnt and go to GAP. If cm_cnt reaches MAX_CM, record MAX_CM as a timeout and go to GAP.
  - GAP: count GAP_CYC cycles. Then advance ch_idx (N_CH-1 wraps to 0). If enable is high, go to TRIG; otherwise go to IDLE.
- Record (normal): dist_cm[ch] = cm_cnt = floor(high_cycles/CM_CYC). Set valid[ch]=1 for one cycle and clear timeout[ch].
- Record (timeout): dist_cm[ch] = MAX_CM. Set valid[ch]=1 for one cycle and set timeout[ch].
- enable is sampled only in IDLE and at the end of GAP. Deasserting it mid-cycle completes the current channel including its GAP.
- An echo already high on entering WAIT_RISE is not a rising edge. The channel waits for a fresh rise.
- Echo activity on channels other than ch_idx is ignored.

## Timing
- Reset values:
  - trig=0, dist_cm=0, valid=0, timeout=0, busy=0, ch_idx=0, FSM=IDLE.
  - Synchronisers and counters are cleared.
- Reset asserted mid-operation forces trig low asynchronously. No partial result is published.
- trig rises on the cycle after IDLE→TRIG and stays high for exactly TRIG_CYC cycles.
- Echo-to-decision latency is 2 cycles (synchroniser) plus 1 (edge detect).
- The valid strobe and the dist_cm/timeout update occur on the same clock edge, 1 cycle after the decision.
- Per-channel period is TRIG_CYC + wait + measure + GAP_CYC. The full scan is the sum over all N_CH channels.
- If echo falls on the same cycle that cm_cnt reaches MAX_CM, the timeout takes priority.

## Configuration
- TELEMETRE_AVG_EN defined:
  - Each channel keeps its last 4 non-timeout samples.
  - dist_cm publishes (sum+2)>>2, computed in DIST_W+2 bits.
  - The history is empty after reset; until 4 samples exist, the average is over the available samples (1, 2 or 3, divided exactly).
  - Timeouts publish MAX_CM and do not enter the history.
- TELEMETRE_AVG_EN undefined: the raw cm_cnt is published. No history registers exist.

## Test plan
- Bench uses CLK_FREQ_HZ=1_000_000, so CM_CYC=58 and TRIG_CYC=10; N_CH=2; GAP_US=100.
- Single echo: enable=1, ch0 echo high for 580 cycles → trig[0] is 10 cycles wide; dist_cm[0]=10, valid[0] pulses once, timeout[0]=0.
- No echo: ch1 silent for RISE_CYC → dist_cm[1]=400, timeout[1]=1, ch_idx wraps to 0.
- Long echo: ch0 echo held high for 30000 cycles → saturates at 400 with timeout[0]=1. A following 116-cycle echo gives 2 and clears timeout[0].
- Round-robin: both channels echo 290 cycles → trig[0] and trig[1] never overlap; dist_cm=5 on both; the channel order is 0,1,0.
- Abort: assert reset_n=0 mid-MEASURE → trig=0 and all outputs at reset values immediately. After release, the scan restarts at ch0.
- With TELEMETRE_AVG_EN: ch0 samples 10,20,30,40 → published values 10, 15, 20, 25.

Source files
------------

// File: rtl/telemetre_us_multi.sv
`default_nettype none
// ============================================================================
// Module  : telemetre_us_multi
// Brief   : Round-robin N-channel ultrasonic rangefinder, distance in cm.
//           Define TELEMETRE_AVG_EN to publish a 4-sample running average.
// Rev     : 1.0
// ============================================================================
module telemetre_us_multi #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int N_CH        = 4,
    parameter int DIST_W      = 10,
    parameter int MAX_CM      = 400,
    parameter int TRIG_US     = 10,
    parameter int RISE_TO_US  = 30000,
    parameter int GAP_US      = 60000,
    localparam int c_CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trig,
    output logic [N_CH*DIST_W-1:0]   dist_cm,
    output logic [N_CH-1:0]          valid,
    output logic [N_CH-1:0]          timeout,
    output logic                     busy,
    output logic [c_CH_W-1:0]        ch_idx
);

    localparam longint c_TRIG_CYC = longint'(TRIG_US)    * CLK_FREQ_HZ / 1_000_000;
    localparam longint c_CM_CYC   = longint'(58)         * CLK_FREQ_HZ / 1_000_000;
    localparam longint c_RISE_CYC = longint'(RISE_TO_US) * CLK_FREQ_HZ / 1_000_000;
    localparam longint c_GAP_CYC  = longint'(GAP_US)     * CLK_FREQ_HZ / 1_000_000;
    localparam longint c_CNT_MAX  = (c_TRIG_CYC > c_RISE_CYC)
                                    ? ((c_TRIG_CYC > c_GAP_CYC) ? c_TRIG_CYC : c_GAP_CYC)
                                    : ((c_RISE_CYC > c_GAP_CYC) ? c_RISE_CYC : c_GAP_CYC);
    localparam int     c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int     c_PS_W     = (c_CM_CYC > 1) ? $clog2(c_CM_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_TRIG_LAST = c_CNT_W'(c_TRIG_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RISE_LAST = c_CNT_W'(c_RISE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(c_GAP_CYC - 1);
    localparam logic [c_PS_W-1:0]  c_PS_LAST   = c_PS_W'(c_CM_CYC - 1);
    // The rising-edge cycle is itself a high cycle, so measurement starts one count in.
    localparam logic [c_PS_W-1:0]  c_PS_INIT   = (c_CM_CYC > 1) ? c_PS_W'(1) : c_PS_W'(0);
    localparam logic [DIST_W-1:0]  c_CM_INIT   = (c_CM_CYC > 1) ? DIST_W'(0) : DIST_W'(1);
    localparam logic [DIST_W-1:0]  c_MAX       = DIST_W'(MAX_CM);
    localparam logic [c_CH_W-1:0]  c_CH_LAST   = c_CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t              r_state;
    logic [N_CH-1:0]     r_echo_s1, r_echo_s2, r_echo_d;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PS_W-1:0]   r_presc;
    logic [DIST_W-1:0]   r_cm;
    logic [c_CH_W-1:0]   r_ch;
    logic [N_CH-1:0]     r_trig;
    logic                r_pend, r_pend_to;
    logic [DIST_W-1:0]   r_pend_cm;
    logic [c_CH_W-1:0]   r_pend_ch;
    logic [DIST_W-1:0]   r_dist [N_CH];
    logic [N_CH-1:0]     r_valid, r_timeout;

    logic                w_echo_cur, w_rise, w_fall;
    logic [c_CH_W-1:0]   w_ch_next;
    logic [DIST_W-1:0]   w_pub;

    assign w_echo_cur = r_echo_s2[r_ch];
    assign w_rise     = w_echo_cur & ~r_echo_d[r_ch];
    assign w_fall     = ~w_echo_cur & r_echo_d[r_ch];
    assign w_ch_next  = (r_ch == c_CH_LAST) ? '0 : r_ch + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
            r_echo_d  <= '0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_presc   <= '0;
            r_cm      <= '0;
            r_ch      <= '0;
            r_trig    <= '0;
            r_pend    <= 1'b0;
            r_pend_to <= 1'b0;
            r_pend_cm <= '0;
            r_pend_ch <= '0;
        end else begin
            r_pend <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state <= S_TRIG;
                        r_trig  <= N_CH'(1) << r_ch;
                        r_cnt   <= '0;
                    end
                end
                S_TRIG: begin
                    if (r_cnt == c_TRIG_LAST) begin
                        r_trig  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RISE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_RISE: begin
                    if (w_rise) begin
                        r_presc <= c_PS_INIT;
                        r_cm    <= c_CM_INIT;
                        r_state <= S_MEASURE;
                    end else if (r_cnt == c_RISE_LAST) begin
                        r_pend    <= 1'b1;
                        r_pend_to <= 1'b1;
                        r_pend_cm <= c_MAX;
                        r_pend_ch <= r_ch;
                        r_cnt     <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    // Saturation wins over a simultaneous falling edge.
                    if (r_cm == c_MAX || w_fall) begin
                        r_pend    <= 1'b1;
                        r_pend_to <= (r_cm == c_MAX);
                        r_pend_cm <= r_cm;
                        r_pend_ch <= r_ch;
                        r_cnt     <= '0;
                        r_state   <= S_GAP;
                    end else if (r_presc == c_PS_LAST) begin
                        r_presc <= '0;
                        r_cm    <= r_cm + 1'b1;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == c_GAP_LAST) begin
                        r_cnt <= '0;
                        r_ch  <= w_ch_next;
                        if (enable) begin
                            r_state <= S_TRIG;
                            r_trig  <= N_CH'(1) << w_ch_next;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trig  <= '0;
                end
            endcase
        end
    end

`ifdef TELEMETRE_AVG_EN
    // Three previous samples per channel; with the new one they form the 4-sample window.
    logic [DIST_W-1:0]   r_hist [N_CH][3];
    logic [1:0]          r_hcnt [N_CH];
    logic [DIST_W+1:0]   w_sum, w_avg;
    logic [1:0]          w_hn;

    always_comb begin
        w_hn  = r_hcnt[r_pend_ch];
        w_sum = {2'b00, r_pend_cm};
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < w_hn) begin
                w_sum = w_sum + {2'b00, r_hist[r_pend_ch][i]};
            end
        end
        case (w_hn)
            2'd0:    w_avg = w_sum;
            2'd1:    w_avg = (w_sum + (DIST_W+2)'(1)) >> 1;
            2'd2:    w_avg = (w_sum + (DIST_W+2)'(1)) / (DIST_W+2)'(3);
            default: w_avg = (w_sum + (DIST_W+2)'(2)) >> 2;
        endcase
        w_pub = w_avg[DIST_W-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < N_CH; c++) begin
                r_hcnt[c] <= '0;
                for (int i = 0; i < 3; i++) begin
                    r_hist[c][i] <= '0;
                end
            end
        end else if (r_pend && !r_pend_to) begin
            r_hist[r_pend_ch][2] <= r_hist[r_pend_ch][1];
            r_hist[r_pend_ch][1] <= r_hist[r_pend_ch][0];
            r_hist[r_pend_ch][0] <= r_pend_cm;
            if (r_hcnt[r_pend_ch] != 2'd3) begin
                r_hcnt[r_pend_ch] <= r_hcnt[r_pend_ch] + 2'd1;
            end
        end
    end
`else
    assign w_pub = r_pend_cm;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= '0;
            r_timeout <= '0;
            for (int c = 0; c < N_CH; c++) begin
                r_dist[c] <= '0;
            end
        end else begin
            r_valid <= '0;
            if (r_pend) begin
                r_valid[r_pend_ch]   <= 1'b1;
                r_timeout[r_pend_ch] <= r_pend_to;
                r_dist[r_pend_ch]    <= r_pend_to ? c_MAX : w_pub;
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_dist
        assign dist_cm[g*DIST_W +: DIST_W] = r_dist[g];
    end

    assign trig    = r_trig;
    assign valid   = r_valid;
    assign timeout = r_timeout;
    assign busy    = (r_state != S_IDLE);
    assign ch_idx  = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_telemetre_us_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_telemetre_us_multi
// Brief   : Self-checking bench for telemetre_us_multi (2 channels, 1 MHz).
// Rev     : 1.0
// ============================================================================
module tb_telemetre_us_multi;

    localparam int N_CH     = 2;
    localparam int DIST_W   = 10;
    localparam int MAX_CM   = 400;
    localparam int CM_CYC   = 58;
    localparam int TRIG_CYC = 10;

    logic                    clk     = 1'b0;
    logic                    reset_n = 1'b1;
    logic                    enable  = 1'b0;
    logic [N_CH-1:0]         echo    = '0;
    logic [N_CH-1:0]         trig, valid, timeout;
    logic [N_CH*DIST_W-1:0]  dist_cm;
    logic                    busy;
    logic [0:0]              ch_idx;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap_cnt = 0;

    typedef struct {
        int ch;
        int dly;
        int width;
        int exp_dist;
        bit exp_to;
    } vec_t;

    telemetre_us_multi #(
        .CLK_FREQ_HZ (1_000_000),
        .N_CH        (N_CH),
        .DIST_W      (DIST_W),
        .MAX_CM      (MAX_CM),
        .TRIG_US     (10),
        .RISE_TO_US  (10000),
        .GAP_US      (100)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .echo    (echo),
        .trig    (trig),
        .dist_cm (dist_cm),
        .valid   (valid),
        .timeout (timeout),
        .busy    (busy),
        .ch_idx  (ch_idx)
    );

    always #500 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(trig) > 1) overlap_cnt++;
    end

    initial begin
        #150_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: distance is whole centimetres of echo width, saturating into a timeout.
    function automatic void raw_model(input int w, output int d, output bit to);
        if (w == 0 || w >= MAX_CM * CM_CYC) begin
            d  = MAX_CM;
            to = 1'b1;
        end else begin
            d  = w / CM_CYC;
            to = 1'b0;
        end
    endfunction

`ifdef TELEMETRE_AVG_EN
    int hist [N_CH][$];

    function automatic int avg_model(input int ch, input int d, input bit to);
        int s = 0;
        int n;
        if (to) return d;
        hist[ch].push_front(d);
        if (hist[ch].size() > 4) void'(hist[ch].pop_back());
        n = hist[ch].size();
        foreach (hist[ch][i]) s += hist[ch][i];
        return (2 * s + n) / (2 * n);
    endfunction
`endif

    task automatic wait_trig(input string tag, output bit got);
        got = 1'b0;
        for (int t = 0; t < 20000; t++) begin
            @(negedge clk);
            if (trig != '0) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_trig_seen"}, 32'(got), 32'd1);
    endtask

    task automatic measure(input string tag, input int exp_ch, input int dly, input int w,
                           input int exp_d, input bit exp_to, input bit drop_en);
        bit got;
        int tw;
        int d;
        wait_trig(tag, got);
        if (!got) return;
        check({tag, "_trig_ch"}, 32'(trig[1] ? 1 : 0), 32'(exp_ch));
        check({tag, "_ch_idx"}, 32'(ch_idx), 32'(exp_ch));
        if (drop_en) enable = 1'b0;
        tw = 0;
        while (trig != '0 && tw < 100) begin
            tw++;
            @(negedge clk);
        end
        check({tag, "_trig_w"}, 32'(tw), 32'(TRIG_CYC));
        repeat (dly) @(negedge clk);
        if (w > 0) begin
            fork
                begin
                    automatic int fc = exp_ch;
                    automatic int fw = w;
                    echo[fc] = 1'b1;
                    repeat (fw) @(negedge clk);
                    echo[fc] = 1'b0;
                end
            join_none
        end
        got = 1'b0;
        for (int t = 0; t < 40000; t++) begin
            if (valid[exp_ch]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_valid_seen"}, 32'(got), 32'd1);
        if (!got) return;
`ifdef TELEMETRE_AVG_EN
        d = avg_model(exp_ch, exp_d, exp_to);
`else
        d = exp_d;
`endif
        check({tag, "_dist"}, 32'(dist_cm[exp_ch*DIST_W +: DIST_W]), 32'(d));
        check({tag, "_timeout"}, 32'(timeout[exp_ch]), 32'(exp_to));
        @(negedge clk);
        check({tag, "_valid_1cyc"}, 32'(valid[exp_ch]), 32'd0);
    endtask

    initial begin
        vec_t tbl [10];
        int d;
        bit to;
        bit got;
        int c;
        int tcount;

        tbl[0] = '{0,   20,   580,  10, 1'b0};
        tbl[1] = '{1,    0,     0, 400, 1'b1};
        tbl[2] = '{0,   20, 30000, 400, 1'b1};
        // Echo of ch0 is still high when it re-arms: only the later fresh rise counts.
        tbl[3] = '{1,   10,   290,   5, 1'b0};
        tbl[4] = '{0, 7000,   116,   2, 1'b0};
        tbl[5] = '{1,    5,   290,   5, 1'b0};
        tbl[6] = '{0,    5,   290,   5, 1'b0};
        tbl[7] = '{1,    3,   579,   9, 1'b0};
        tbl[8] = '{0,    3,    57,   0, 1'b0};
        tbl[9] = '{1,    3,    58,   1, 1'b0};

        #100;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig",    32'(trig),    32'd0);
        check("rst_dist",    32'(dist_cm), 32'd0);
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_ch_idx",  32'(ch_idx),  32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        for (int i = 0; i < 10; i++) begin
            measure($sformatf("vec%0d", i), tbl[i].ch, tbl[i].dly, tbl[i].width,
                    tbl[i].exp_dist, tbl[i].exp_to, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            automatic int w   = $urandom_range(1, 1500);
            automatic int dly = $urandom_range(0, 300);
            raw_model(w, d, to);
            measure($sformatf("rnd%0d", i), i % 2, dly, w, d, to, 1'b0);
        end

        // Abort in the middle of a measurement.
        wait_trig("abort", got);
        if (got) begin
            c = trig[1] ? 1 : 0;
            while (trig != '0) @(negedge clk);
            repeat (5) @(negedge clk);
            echo[c] = 1'b1;
            repeat (200) @(negedge clk);
            check("abort_busy_pre", 32'(busy), 32'd1);
            reset_n = 1'b0;
            #1;
            check("abort_trig",    32'(trig),    32'd0);
            check("abort_dist",    32'(dist_cm), 32'd0);
            check("abort_valid",   32'(valid),   32'd0);
            check("abort_timeout", 32'(timeout), 32'd0);
            check("abort_busy",    32'(busy),    32'd0);
            check("abort_ch_idx",  32'(ch_idx),  32'd0);
            echo = '0;
            repeat (3) @(negedge clk);
`ifdef TELEMETRE_AVG_EN
            for (int k = 0; k < N_CH; k++) hist[k].delete();
`endif
            reset_n = 1'b1;
        end

        measure("restart", 0, 5, 290, 5, 1'b0, 1'b0);
        // Dropping enable mid-channel still completes that channel and its gap.
        measure("stop", 1, 5, 116, 2, 1'b0, 1'b1);
        repeat (150) @(negedge clk);
        check("stop_busy",   32'(busy),   32'd0);
        check("stop_ch_idx", 32'(ch_idx), 32'd0);
        tcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (trig != '0) tcount++;
        end
        check("stop_no_trig", 32'(tcount), 32'd0);
        enable = 1'b1;
        measure("resume", 0, 8, 1160, 20, 1'b0, 1'b0);

        check("trig_overlap", 32'(overlap_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
